mr_retire: RTL and testbench
============================

MR_RETIRE -- requirements
Module: mr_retire

Interface
REQ-001 SHALL have parameter DEPTH, default `RETQUEUE_SIZE, retire-queue entries (power of two, 2..32).
REQ-002 SHALL have parameter IDW, default `INSTID_BITS, instruction-ID width (= log2 DEPTH).
REQ-003 SHALL have parameter PCW, default `IMAXLEN; parameter DW, default `XLEN, result width.
REQ-004 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have: alloc_valid  in  1  slot allocated this cycle; alloc_id  in  IDW  allocated ID; alloc_pc  in  PCW  its PC.
REQ-006 SHALL have: cmpl_valid  in  1  completion report; cmpl_id  in  IDW; cmpl_rd  in  5  dest reg; cmpl_data  in  DW  result; cmpl_exc  in  1  faulted.
REQ-007 SHALL have: free_valid  out  1  slot released; free_id  out  IDW; retire_pc  out  PCW  PC of retiring inst.
REQ-008 SHALL have: rf_we  out  1; rf_rd  out  5; rf_wdata  out  DW  register-file write.
REQ-009 SHALL have: busy  out  1  queue non-empty; retired_count  out  32  normal retirements.

Function
REQ-010 SHALL record alloc_id in an in-order age FIFO at each alloc_valid, and store alloc_pc in the per-ID PC table, and clear that ID's done bit.
REQ-011 SHALL on cmpl_valid store cmpl_rd, cmpl_data, cmpl_exc at index cmpl_id and set done[cmpl_id].
REQ-012 SHALL retire at most one instruction per cycle, only the FIFO head, only when FIFO non-empty and done[head] is set.
REQ-013 SHALL drive retire outputs combinationally from registered state; a completion in cycle N retires no earlier than cycle N+1.
REQ-014 SHALL on normal retire assert free_valid, free_id=head ID, retire_pc=PC[head], rf_we=(rd!=0), rf_rd, rf_wdata for that one cycle, pop FIFO, increment retired_count (wraps at 2^32).
REQ-015 SHALL hold all retire outputs at 0 in cycles with no retirement.
REQ-016 SHALL accept alloc and retire in the same cycle, including when FIFO full; occupancy unchanged.
REQ-017 SHALL accept a completion for the head ID only from the following cycle (no same-cycle bypass).
REQ-018 SHALL flag by assertion: alloc_valid when full and not retiring; cmpl_id not in FIFO; second completion for a done ID.
REQ-019 SHALL ignore (no state change) completions failing REQ-018 checks in synthesis.
REQ-020 SHALL assert busy whenever FIFO occupancy > 0.
REQ-021 SHALL keep occupancy counter IDW+1 bits wide; head/tail pointers IDW bits, wrapping modulo DEPTH.

Reset
REQ-022 SHALL on rst clear FIFO pointers, occupancy, all done bits, retired_count, and state to RUN; all outputs 0 the cycle after.
REQ-023 SHALL let rst override alloc, completion and flush in the same cycle, discarding in-flight entries.

Configuration
REQ-024 SHALL compile precise-exception flush only when MR_RETIRE_EXC_EN is defined.
REQ-025 With MR_RETIRE_EXC_EN: ports flush out 1 and flush_pc out PCW; states RUN and FLUSH.
REQ-026 With MR_RETIRE_EXC_EN: head done with exc in RUN -> flush=1, flush_pc=PC[head], free_valid=0, rf_we=0, retired_count unchanged; next state FLUSH.
REQ-027 With MR_RETIRE_EXC_EN: FLUSH lasts exactly one cycle, clears FIFO and done bits, retires nothing, then returns to RUN; alloc_valid in FLUSH is an assertion error and ignored.
REQ-028 Without MR_RETIRE_EXC_EN: no flush ports, cmpl_exc ignored, faulting instruction retires normally.

Structure
REQ-029 SHALL place inst_id_t (IDW bits) and retire-entry struct (rd, data, exc) in shared package mr_pkg.
REQ-030 SHALL implement the age FIFO as sub-module mr_id_fifo (push, pop, clear, head, full, empty, count).

Verification
REQ-031 Alloc IDs 0,1,2 (PCs 0x100,0x104,0x108); complete 2,0,1 with rd 5,6,7 -> retires in order 0,1,2 on consecutive cycles, rf_rd 6,7,5, retired_count=3.
REQ-032 Alloc ID 3, complete rd=0 data 0xDEAD -> free_valid=1 free_id=3, rf_we=0, retired_count+1.
REQ-033 Fill DEPTH entries, head done, alloc freed ID same cycle as retire -> no assertion, busy stays 1, occupancy DEPTH.
REQ-034 EXC_EN: alloc 0,1 (0x200,0x204), complete 0 with exc -> flush=1 flush_pc=0x200 one cycle, then busy=0, later completion of 1 ignored.
REQ-035 Alloc 4 entries, complete 2, assert rst -> next cycle busy=0, all outputs 0, retired_count=0.
REQ-036 Complete ID never allocated -> assertion fires, no retire, state unchanged.

Source files
------------

// File: rtl/mr_pkg.sv
// Shared types for the retire unit: instruction ID, per-ID completion entry and FSM states.
// Default sizing macros are supplied here when the surrounding codebase does not define them.
`ifndef RETQUEUE_SIZE
`define RETQUEUE_SIZE 8
`endif
`ifndef INSTID_BITS
`define INSTID_BITS 3
`endif
`ifndef IMAXLEN
`define IMAXLEN 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

package mr_pkg;
  localparam int MR_IDW = `INSTID_BITS;
  localparam int MR_DW  = `XLEN;

  typedef logic [MR_IDW-1:0] inst_id_t;

  typedef struct packed {
    logic [4:0]       rd;
    logic [MR_DW-1:0] data;
    logic             exc;
  } ret_entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } ret_state_t;
endpackage

// File: rtl/mr_id_fifo.sv
// In-order age FIFO of instruction IDs; push and pop may coincide even when full.
module mr_id_fifo
  import mr_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDW   = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic [IDW-1:0] push_id,
  input  logic           pop,
  input  logic           clear,
  output logic [IDW-1:0] head,
  output logic           full,
  output logic           empty,
  output logic [IDW:0]   count
);

  logic [IDW-1:0] r_mem [DEPTH];
  logic [IDW-1:0] r_head;
  logic [IDW-1:0] r_tail;
  logic [IDW:0]   r_count;
  logic           w_push;
  logic           w_pop;

  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  // Pointers wrap naturally because DEPTH is exactly 2**IDW.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      r_count <= r_count + (IDW+1)'(w_push) - (IDW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= push_id;
  end

  assign head  = r_mem[r_head];
  assign full  = (r_count == (IDW+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

// File: rtl/mr_retire.sv
// In-order retire stage: tracks allocated IDs by age, collects completions, retires the head.
// Optional precise-exception flush is built when MR_RETIRE_EXC_EN is defined.
`ifndef RETQUEUE_SIZE
`define RETQUEUE_SIZE 8
`endif
`ifndef INSTID_BITS
`define INSTID_BITS 3
`endif
`ifndef IMAXLEN
`define IMAXLEN 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module mr_retire
  import mr_pkg::*;
#(
  parameter int DEPTH = `RETQUEUE_SIZE,
  parameter int IDW   = `INSTID_BITS,
  parameter int PCW   = `IMAXLEN,
  parameter int DW    = `XLEN
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           alloc_valid,
  input  logic [IDW-1:0] alloc_id,
  input  logic [PCW-1:0] alloc_pc,
  input  logic           cmpl_valid,
  input  logic [IDW-1:0] cmpl_id,
  input  logic [4:0]     cmpl_rd,
  input  logic [DW-1:0]  cmpl_data,
  input  logic           cmpl_exc,
  output logic           free_valid,
  output logic [IDW-1:0] free_id,
  output logic [PCW-1:0] retire_pc,
  output logic           rf_we,
  output logic [4:0]     rf_rd,
  output logic [DW-1:0]  rf_wdata,
`ifdef MR_RETIRE_EXC_EN
  output logic           flush,
  output logic [PCW-1:0] flush_pc,
`endif
  output logic           busy,
  output logic [31:0]    retired_count
);

  logic [PCW-1:0] r_pc  [DEPTH];
  ret_entry_t     r_ent [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_done;
  logic [31:0]      r_retired;

  logic [IDW-1:0] w_head_id;
  logic           w_full;
  logic           w_empty;
  logic [IDW:0]   w_count;
  ret_entry_t     w_head_ent;
  logic [PCW-1:0] w_head_pc;
  logic           w_head_done;
  logic           w_run;
  logic           w_retire;
  logic           w_flush_clr;
  logic           w_alloc_ok;
  logic           w_cmpl_ok;

  assign w_head_ent  = r_ent[w_head_id];
  assign w_head_pc   = r_pc[w_head_id];
  assign w_head_done = !w_empty && r_done[w_head_id];

`ifdef MR_RETIRE_EXC_EN
  ret_state_t r_state;
  ret_state_t w_state_next;
  logic       w_flush_go;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_flush_go   = 1'b0;
    w_flush_clr  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_head_done && w_head_ent.exc) begin
          w_flush_go   = 1'b1;
          w_state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        w_flush_clr  = 1'b1;
        w_state_next = ST_RUN;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  assign w_run    = (r_state == ST_RUN);
  assign w_retire = w_run && w_head_done && !w_head_ent.exc;
  assign flush    = w_flush_go;
  assign flush_pc = w_flush_go ? w_head_pc : '0;
`else
  logic w_unused_exc;

  // Faults are not tracked in this build; the stored exc bit is simply dropped.
  assign w_run        = 1'b1;
  assign w_flush_clr  = 1'b0;
  assign w_retire     = w_head_done;
  assign w_unused_exc = w_head_ent.exc;
`endif

  assign w_alloc_ok = alloc_valid && w_run && (!w_full || w_retire);
  assign w_cmpl_ok  = cmpl_valid && w_run && r_valid[cmpl_id] && !r_done[cmpl_id];

  mr_id_fifo #(
    .DEPTH(DEPTH),
    .IDW  (IDW)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (w_alloc_ok),
    .push_id(alloc_id),
    .pop    (w_retire),
    .clear  (w_flush_clr),
    .head   (w_head_id),
    .full   (w_full),
    .empty  (w_empty),
    .count  (w_count)
  );

  // Alloc is applied last so a freed ID reallocated in the retire cycle stays live.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= '0;
      r_done    <= '0;
      r_retired <= '0;
    end else if (w_flush_clr) begin
      r_valid <= '0;
      r_done  <= '0;
    end else begin
      if (w_retire) begin
        r_valid[w_head_id] <= 1'b0;
        r_done[w_head_id]  <= 1'b0;
        r_retired          <= r_retired + 32'd1;
      end
      if (w_cmpl_ok) r_done[cmpl_id] <= 1'b1;
      if (w_alloc_ok) begin
        r_valid[alloc_id] <= 1'b1;
        r_done[alloc_id]  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_alloc_ok) r_pc[alloc_id] <= alloc_pc;
    if (w_cmpl_ok)  r_ent[cmpl_id] <= '{rd: cmpl_rd, data: cmpl_data, exc: cmpl_exc};
  end

  assign free_valid    = w_retire;
  assign free_id       = w_retire ? w_head_id : '0;
  assign retire_pc     = w_retire ? w_head_pc : '0;
  assign rf_we         = w_retire && (w_head_ent.rd != 5'd0);
  assign rf_rd         = w_retire ? w_head_ent.rd : 5'd0;
  assign rf_wdata      = w_retire ? w_head_ent.data : '0;
  assign busy          = (w_count != '0);
  assign retired_count = r_retired;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_alloc_full: assert (!(alloc_valid && w_run && w_full && !w_retire))
        else $warning("mr_retire: alloc while queue full");
`ifdef MR_RETIRE_EXC_EN
      a_alloc_flush: assert (!(alloc_valid && !w_run))
        else $warning("mr_retire: alloc during flush");
`endif
      a_cmpl_unknown: assert (!(cmpl_valid && !r_valid[cmpl_id]))
        else $warning("mr_retire: completion for ID not in queue");
      a_cmpl_twice: assert (!(cmpl_valid && r_valid[cmpl_id] && r_done[cmpl_id]))
        else $warning("mr_retire: second completion for done ID");
    end
  end
`endif

endmodule

// File: tb/tb_mr_retire.sv
// Directed bench for mr_retire (default sizing: 8 entries, 3-bit IDs, 32-bit PC/data).
module tb_mr_retire;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [2:0]  alloc_id;
  logic [31:0] alloc_pc;
  logic        cmpl_valid;
  logic [2:0]  cmpl_id;
  logic [4:0]  cmpl_rd;
  logic [31:0] cmpl_data;
  logic        cmpl_exc;
  logic        free_valid;
  logic [2:0]  free_id;
  logic [31:0] retire_pc;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
`ifdef MR_RETIRE_EXC_EN
  logic        flush;
  logic [31:0] flush_pc;
`endif
  logic        busy;
  logic [31:0] retired_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mr_retire dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_valid  (alloc_valid),
    .alloc_id     (alloc_id),
    .alloc_pc     (alloc_pc),
    .cmpl_valid   (cmpl_valid),
    .cmpl_id      (cmpl_id),
    .cmpl_rd      (cmpl_rd),
    .cmpl_data    (cmpl_data),
    .cmpl_exc     (cmpl_exc),
    .free_valid   (free_valid),
    .free_id      (free_id),
    .retire_pc    (retire_pc),
    .rf_we        (rf_we),
    .rf_rd        (rf_rd),
    .rf_wdata     (rf_wdata),
`ifdef MR_RETIRE_EXC_EN
    .flush        (flush),
    .flush_pc     (flush_pc),
`endif
    .busy         (busy),
    .retired_count(retired_count)
  );

  // Checks happen at the falling edge, then inputs for the next rising edge are driven.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    alloc_valid = 1'b0; alloc_id = '0; alloc_pc = '0;
    cmpl_valid = 1'b0; cmpl_id = '0; cmpl_rd = '0; cmpl_data = '0; cmpl_exc = 1'b0;
  endtask

  task automatic alloc(input logic [2:0] id, input logic [31:0] pc);
    alloc_valid = 1'b1; alloc_id = id; alloc_pc = pc;
  endtask

  task automatic cmpl(input logic [2:0] id, input logic [4:0] rd, input logic [31:0] d, input logic exc);
    cmpl_valid = 1'b1; cmpl_id = id; cmpl_rd = rd; cmpl_data = d; cmpl_exc = exc;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    cyc(); cyc();
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_checks++; if (free_valid !== 1'b0) begin n_errors++; $display("FAIL reset_free_valid: got %0b want 0", free_valid); end
    n_checks++; if (retired_count !== 32'd0) begin n_errors++; $display("FAIL reset_count: got %0d want 0", retired_count); end
    n_checks++; if (rf_we !== 1'b0) begin n_errors++; $display("FAIL reset_rf_we: got %0b want 0", rf_we); end
    $display("reset: busy=%0b free_valid=%0b count=%0d", busy, free_valid, retired_count);
  endtask

  task automatic test_in_order();
    logic [2:0]  exp_id [3] = '{3'd0, 3'd1, 3'd2};
    logic [31:0] exp_pc [3] = '{32'h100, 32'h104, 32'h108};
    logic [4:0]  exp_rd [3] = '{5'd6, 5'd7, 5'd5};
    logic [31:0] exp_d  [3] = '{32'h66, 32'h77, 32'h55};
    alloc(3'd0, 32'h100); cyc();
    alloc(3'd1, 32'h104); cyc();
    alloc(3'd2, 32'h108); cyc();
    idle(); cmpl(3'd2, 5'd5, 32'h55, 1'b0);
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL order_busy: got %0b want 1", busy); end
    cyc();
    n_checks++; if (free_valid !== 1'b0) begin n_errors++; $display("FAIL order_no_early_retire: got %0b want 0", free_valid); end
    cmpl(3'd0, 5'd6, 32'h66, 1'b0);
    cyc();
    cmpl(3'd1, 5'd7, 32'h77, 1'b0);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) idle();
      $display("retire: valid=%0b id=%0d pc=%h rd=%0d we=%0b data=%h", free_valid, free_id, retire_pc, rf_rd, rf_we, rf_wdata);
      n_checks++; if (free_valid !== 1'b1 || free_id !== exp_id[k]) begin n_errors++; $display("FAIL order_id%0d: got v=%0b id=%0d want v=1 id=%0d", k, free_valid, free_id, exp_id[k]); end
      n_checks++; if (retire_pc !== exp_pc[k]) begin n_errors++; $display("FAIL order_pc%0d: got %h want %h", k, retire_pc, exp_pc[k]); end
      n_checks++; if (rf_we !== 1'b1 || rf_rd !== exp_rd[k] || rf_wdata !== exp_d[k]) begin n_errors++; $display("FAIL order_rf%0d: got we=%0b rd=%0d d=%h want we=1 rd=%0d d=%h", k, rf_we, rf_rd, rf_wdata, exp_rd[k], exp_d[k]); end
      cyc();
    end
    n_checks++; if (free_valid !== 1'b0 || rf_we !== 1'b0) begin n_errors++; $display("FAIL order_idle_out: got v=%0b we=%0b want 0 0", free_valid, rf_we); end
    n_checks++; if (retired_count !== 32'd3) begin n_errors++; $display("FAIL order_count: got %0d want 3", retired_count); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL order_busy_end: got %0b want 0", busy); end
  endtask

  task automatic test_rd_zero();
    alloc(3'd3, 32'h10C); cyc();
    idle(); cmpl(3'd3, 5'd0, 32'hDEAD, 1'b0); cyc();
    idle();
    $display("retire: valid=%0b id=%0d pc=%h rd=%0d we=%0b", free_valid, free_id, retire_pc, rf_rd, rf_we);
    n_checks++; if (free_valid !== 1'b1 || free_id !== 3'd3) begin n_errors++; $display("FAIL rd0_free: got v=%0b id=%0d want v=1 id=3", free_valid, free_id); end
    n_checks++; if (rf_we !== 1'b0) begin n_errors++; $display("FAIL rd0_we: got %0b want 0", rf_we); end
    n_checks++; if (retire_pc !== 32'h10C) begin n_errors++; $display("FAIL rd0_pc: got %h want 10c", retire_pc); end
    cyc();
    n_checks++; if (retired_count !== 32'd4) begin n_errors++; $display("FAIL rd0_count: got %0d want 4", retired_count); end
  endtask

  task automatic test_full_back_to_back();
    logic [2:0] seq [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    for (int i = 0; i < 8; i++) begin
      alloc(3'(i), 32'h300 + 32'(4 * i)); cyc();
    end
    idle(); cmpl(3'd0, 5'd1, 32'h1, 1'b0); cyc();
    idle(); alloc(3'd0, 32'h400);
    $display("retire+alloc: valid=%0b id=%0d busy=%0b", free_valid, free_id, busy);
    n_checks++; if (free_valid !== 1'b1 || free_id !== 3'd0) begin n_errors++; $display("FAIL full_retire: got v=%0b id=%0d want v=1 id=0", free_valid, free_id); end
    cyc();
    idle();
    n_checks++; if (busy !== 1'b1 || free_valid !== 1'b0) begin n_errors++; $display("FAIL full_hold: got busy=%0b v=%0b want 1 0", busy, free_valid); end
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        n_checks++; if (free_valid !== 1'b1 || free_id !== seq[k-1] || retire_pc !== 32'h300 + 32'(4 * seq[k-1])) begin n_errors++; $display("FAIL full_drain%0d: got v=%0b id=%0d pc=%h want id=%0d", k, free_valid, free_id, retire_pc, seq[k-1]); end
      end
      cmpl(seq[k], 5'(k + 1), 32'(k), 1'b0); cyc();
    end
    idle();
    $display("retire: valid=%0b id=%0d pc=%h", free_valid, free_id, retire_pc);
    n_checks++; if (free_valid !== 1'b1 || free_id !== 3'd0 || retire_pc !== 32'h400) begin n_errors++; $display("FAIL full_last: got v=%0b id=%0d pc=%h want v=1 id=0 pc=400", free_valid, free_id, retire_pc); end
    cyc();
    n_checks++; if (busy !== 1'b0 || retired_count !== 32'd13) begin n_errors++; $display("FAIL full_end: got busy=%0b count=%0d want 0 13", busy, retired_count); end
  endtask

  task automatic test_reset_inflight();
    for (int i = 0; i < 4; i++) begin
      alloc(3'(i), 32'h500 + 32'(4 * i)); cyc();
    end
    idle(); cmpl(3'd2, 5'd3, 32'h3, 1'b0); cyc();
    rst = 1'b1; alloc(3'd4, 32'h510); cmpl(3'd0, 5'd4, 32'h4, 1'b0); cyc();
    rst = 1'b0; idle();
    $display("reset_inflight: busy=%0b valid=%0b count=%0d", busy, free_valid, retired_count);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy: got %0b want 0", busy); end
    n_checks++; if (free_valid !== 1'b0 || rf_we !== 1'b0 || free_id !== 3'd0 || retire_pc !== 32'd0) begin n_errors++; $display("FAIL rstmid_out: got v=%0b we=%0b id=%0d pc=%h want all 0", free_valid, rf_we, free_id, retire_pc); end
    n_checks++; if (retired_count !== 32'd0) begin n_errors++; $display("FAIL rstmid_count: got %0d want 0", retired_count); end
    cyc();
    n_checks++; if (free_valid !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_after: got v=%0b busy=%0b want 0 0", free_valid, busy); end
  endtask

  task automatic test_bad_cmpl();
    alloc(3'd6, 32'h600); cyc();
    idle(); cmpl(3'd5, 5'd9, 32'h1, 1'b0); cyc();
    idle(); cyc();
    n_checks++; if (free_valid !== 1'b0 || busy !== 1'b1) begin n_errors++; $display("FAIL bad_cmpl_state: got v=%0b busy=%0b want 0 1", free_valid, busy); end
    cmpl(3'd6, 5'd2, 32'h12, 1'b0); cyc();
    idle();
    $display("retire: valid=%0b id=%0d rd=%0d", free_valid, free_id, rf_rd);
    n_checks++; if (free_valid !== 1'b1 || free_id !== 3'd6 || rf_rd !== 5'd2 || rf_wdata !== 32'h12) begin n_errors++; $display("FAIL bad_cmpl_retire: got v=%0b id=%0d rd=%0d d=%h want 1 6 2 12", free_valid, free_id, rf_rd, rf_wdata); end
    cyc();
    n_checks++; if (retired_count !== 32'd1 || busy !== 1'b0) begin n_errors++; $display("FAIL bad_cmpl_count: got %0d busy=%0b want 1 0", retired_count, busy); end
  endtask

`ifdef MR_RETIRE_EXC_EN
  task automatic test_exc();
    alloc(3'd0, 32'h200); cyc();
    alloc(3'd1, 32'h204); cyc();
    idle(); cmpl(3'd0, 5'd3, 32'h9, 1'b1); cyc();
    idle();
    $display("flush: flush=%0b pc=%h valid=%0b", flush, flush_pc, free_valid);
    n_checks++; if (flush !== 1'b1 || flush_pc !== 32'h200) begin n_errors++; $display("FAIL exc_flush: got %0b pc=%h want 1 200", flush, flush_pc); end
    n_checks++; if (free_valid !== 1'b0 || rf_we !== 1'b0) begin n_errors++; $display("FAIL exc_no_retire: got v=%0b we=%0b want 0 0", free_valid, rf_we); end
    cyc();
    n_checks++; if (flush !== 1'b0 || free_valid !== 1'b0) begin n_errors++; $display("FAIL exc_flush_one_cycle: got flush=%0b v=%0b want 0 0", flush, free_valid); end
    cyc();
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL exc_busy: got %0b want 0", busy); end
    cmpl(3'd1, 5'd4, 32'h4, 1'b0); cyc();
    idle(); cyc();
    n_checks++; if (free_valid !== 1'b0 || busy !== 1'b0 || retired_count !== 32'd1) begin n_errors++; $display("FAIL exc_late_cmpl: got v=%0b busy=%0b count=%0d want 0 0 1", free_valid, busy, retired_count); end
  endtask
`else
  task automatic test_exc();
    alloc(3'd1, 32'h204); cyc();
    idle(); cmpl(3'd1, 5'd4, 32'h44, 1'b1); cyc();
    idle();
    $display("retire: valid=%0b id=%0d we=%0b", free_valid, free_id, rf_we);
    n_checks++; if (free_valid !== 1'b1 || free_id !== 3'd1 || rf_we !== 1'b1 || rf_wdata !== 32'h44) begin n_errors++; $display("FAIL exc_normal_retire: got v=%0b id=%0d we=%0b d=%h want 1 1 1 44", free_valid, free_id, rf_we, rf_wdata); end
    cyc();
    n_checks++; if (retired_count !== 32'd2) begin n_errors++; $display("FAIL exc_normal_count: got %0d want 2", retired_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_in_order();
    test_rd_zero();
    test_full_back_to_back();
    test_reset_inflight();
    test_bad_cmpl();
    test_exc();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
